// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access pipeline stage: access sizes,
// trap causes, FSM states and small address helpers.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE   = 2'd0,
        SIZE_HALF   = 2'd1,
        SIZE_WORD   = 2'd2,
        SIZE_DOUBLE = 2'd3
    } size_e;

    localparam logic [4:0] CAUSE_LOAD_MISALIGNED  = 5'd4;
    localparam logic [4:0] CAUSE_LOAD_ACCESS      = 5'd5;
    localparam logic [4:0] CAUSE_STORE_MISALIGNED = 5'd6;
    localparam logic [4:0] CAUSE_STORE_ACCESS     = 5'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Byte-enable pattern for an access of the given size starting at lane 0.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size_e'(size))
            SIZE_BYTE: return 8'h01;
            SIZE_HALF: return 8'h03;
            SIZE_WORD: return 8'h0F;
            default:   return 8'hFF;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] offset, input logic [1:0] size);
        case (size_e'(size))
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return offset[0];
            SIZE_WORD: return |offset[1:0];
            default:   return |offset;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load data alignment: shifts the addressed byte lane down to bit 0 and
// sign- or zero-extends from the access size.
module load_align
    import mem_access_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [63:0] data
);

    logic [63:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        data    = shifted;
        case (size_e'(size))
            SIZE_BYTE: data = {{56{~is_unsigned & shifted[7]}},  shifted[7:0]};
            SIZE_HALF: data = {{48{~is_unsigned & shifted[15]}}, shifted[15:0]};
            SIZE_WORD: data = {{32{~is_unsigned & shifted[31]}}, shifted[31:0]};
            default:   data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MA pipeline stage: issues one load/store at a time on a ready/valid bus,
// formats the response and reports misalignment, bus errors and timeouts.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [63:0] in_pc,
    input  logic [4:0]  in_rd,
    input  logic [63:0] in_result,
    input  logic [63:0] in_data2,
    input  logic [4:0]  in_cause,
    input  logic [63:0] in_tval,
    input  logic        in_load,
    input  logic        in_store,
    input  logic [1:0]  in_size,
    input  logic        in_unsigned,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    input  logic        mem_err,
    output logic        stall_out,
    output logic [63:0] pc_out,
    output logic [4:0]  rd_out,
    output logic [63:0] result_out,
    output logic [4:0]  cause_out,
    output logic [63:0] tval_out
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e             state, state_nx;
    logic [CNT_W-1:0]   tmo_cnt;
    logic [2:0]         offset;
    logic               is_mem, misaligned, timeout_hit;
    logic               take_pass, take_misalign, take_fault, take_data;
    logic [63:0]        load_data;

    assign offset      = in_result[2:0];
    assign is_mem      = (in_load | in_store) && (in_cause == 5'd0);
    assign misaligned  = is_misaligned(offset, in_size);
    assign timeout_hit = (state == ST_WAIT) && !mem_rvalid && (tmo_cnt == CNT_W'(TIMEOUT - 1));

    // Request fields come straight from the stage inputs, which stay frozen while stalled.
    assign mem_we    = in_store;
    assign mem_addr  = {in_result[63:3], 3'b000};
    assign mem_wstrb = size_mask(in_size) << offset;

    always_comb begin
        case (size_e'(in_size))
            SIZE_BYTE: mem_wdata = {8{in_data2[7:0]}};
            SIZE_HALF: mem_wdata = {4{in_data2[15:0]}};
            SIZE_WORD: mem_wdata = {2{in_data2[31:0]}};
            default:   mem_wdata = in_data2;
        endcase
    end

    load_align u_load_align (
        .rdata       (mem_rdata),
        .offset      (offset),
        .size        (in_size),
        .is_unsigned (in_unsigned),
        .data        (load_data)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_nx      = state;
        mem_req       = 1'b0;
        stall_out     = 1'b0;
        take_pass     = 1'b0;
        take_misalign = 1'b0;
        take_fault    = 1'b0;
        take_data     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!clear) begin
                    if (!is_mem) begin
                        take_pass = 1'b1;
                    end else if (misaligned) begin
                        take_misalign = 1'b1;
                    end else begin
                        mem_req   = 1'b1;
                        stall_out = 1'b1;
                        state_nx  = mem_ready ? ST_WAIT : ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (clear) begin
                    state_nx = ST_IDLE;
                end else begin
                    mem_req   = 1'b1;
                    stall_out = 1'b1;
                    if (mem_ready) state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (clear) begin
                    state_nx = mem_rvalid ? ST_IDLE : ST_DRAIN;
                end else if (mem_rvalid) begin
                    take_data  = !mem_err;
                    take_fault = mem_err;
                    state_nx   = ST_IDLE;
                end else if (timeout_hit) begin
                    take_fault = 1'b1;
                    state_nx   = ST_DRAIN;
                end else begin
                    stall_out = 1'b1;
                end
            end
            default: begin
                stall_out = 1'b1;
                if (mem_rvalid) state_nx = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nx;
            tmo_cnt <= (state == ST_WAIT) ? tmo_cnt + CNT_W'(1) : '0;
        end
    end

    // Every cycle not retiring an instruction emits an all-zero bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out     <= '0;
            rd_out     <= '0;
            result_out <= '0;
            cause_out  <= '0;
            tval_out   <= '0;
        end else begin
            pc_out     <= '0;
            rd_out     <= '0;
            result_out <= '0;
            cause_out  <= '0;
            tval_out   <= '0;
            if (take_pass) begin
                pc_out     <= in_pc;
                rd_out     <= in_rd;
                result_out <= in_result;
                cause_out  <= in_cause;
                tval_out   <= in_tval;
            end else if (take_misalign) begin
                pc_out    <= in_pc;
                cause_out <= in_load ? CAUSE_LOAD_MISALIGNED : CAUSE_STORE_MISALIGNED;
                tval_out  <= in_result;
            end else if (take_fault) begin
                pc_out    <= in_pc;
                cause_out <= in_load ? CAUSE_LOAD_ACCESS : CAUSE_STORE_ACCESS;
                tval_out  <= in_result;
            end else if (take_data) begin
                pc_out     <= in_pc;
                rd_out     <= in_store ? 5'd0 : in_rd;
                result_out <= in_load ? load_data : 64'd0;
                tval_out   <= in_tval;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access: inputs change on the falling
// edge, outputs are sampled 1 ns later or on the following falling edge.
module tb_mem_access;
    import mem_access_pkg::*;

    localparam int TIMEOUT = 256;

    logic        clk = 1'b0;
    logic        rst, clear;
    logic [63:0] in_pc, in_result, in_data2, in_tval;
    logic [4:0]  in_rd, in_cause;
    logic        in_load, in_store, in_unsigned;
    logic [1:0]  in_size;
    logic        mem_req, mem_we, mem_ready, mem_rvalid, mem_err, stall_out;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wstrb;
    logic [63:0] pc_out, result_out, tval_out;
    logic [4:0]  rd_out, cause_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_pc(in_pc), .in_rd(in_rd), .in_result(in_result), .in_data2(in_data2),
        .in_cause(in_cause), .in_tval(in_tval), .in_load(in_load), .in_store(in_store),
        .in_size(in_size), .in_unsigned(in_unsigned),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_err(mem_err), .stall_out(stall_out),
        .pc_out(pc_out), .rd_out(rd_out), .result_out(result_out),
        .cause_out(cause_out), .tval_out(tval_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic set_idle;
        clear = 0; in_load = 0; in_store = 0; in_size = 0; in_unsigned = 0;
        in_pc = 0; in_rd = 0; in_result = 0; in_data2 = 0; in_cause = 0; in_tval = 0;
        mem_ready = 0; mem_rvalid = 0; mem_err = 0; mem_rdata = 0;
    endtask

    task automatic set_op(input logic ld, input logic st, input logic [1:0] size, input logic uns,
                          input logic [63:0] addr, input logic [63:0] data,
                          input logic [4:0] rd, input logic [63:0] pc);
        in_load = ld; in_store = st; in_size = size; in_unsigned = uns;
        in_result = addr; in_data2 = data; in_rd = rd; in_pc = pc;
    endtask

    // Load with immediate acceptance and a response on the following cycle.
    task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                           input logic [63:0] addr, input logic [63:0] rdata, input logic [63:0] exp);
        set_idle;
        set_op(1'b1, 1'b0, size, uns, addr, 64'd0, 5'd5, 64'h100);
        mem_ready = 1; #1;
        check({tag, " req"}, {63'd0, mem_req}, 64'd1);
        check({tag, " addr"}, mem_addr, {addr[63:3], 3'b000});
        check({tag, " stall c0"}, {63'd0, stall_out}, 64'd1);
        tick;
        mem_ready = 0; mem_rvalid = 1; mem_rdata = rdata; #1;
        check({tag, " stall c1"}, {63'd0, stall_out}, 64'd0);
        tick;
        check({tag, " result"}, result_out, exp);
        check({tag, " rd"}, {59'd0, rd_out}, 64'd5);
        check({tag, " pc"}, pc_out, 64'h100);
        check({tag, " cause"}, {59'd0, cause_out}, 64'd0);
        set_idle;
    endtask

    task automatic do_store(input string tag, input logic [1:0] size, input logic [63:0] addr,
                            input logic [63:0] data, input logic [7:0] exp_strb, input logic [63:0] exp_wdata);
        set_idle;
        set_op(1'b0, 1'b1, size, 1'b0, addr, data, 5'd0, 64'h180);
        mem_ready = 1; #1;
        check({tag, " we"}, {63'd0, mem_we}, 64'd1);
        check({tag, " wstrb"}, {56'd0, mem_wstrb}, {56'd0, exp_strb});
        check({tag, " wdata"}, mem_wdata, exp_wdata);
        check({tag, " addr"}, mem_addr, 64'h1000);
        tick;
        mem_ready = 0; mem_rvalid = 1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick;
        check({tag, " result"}, result_out, 64'd0);
        check({tag, " cause"}, {59'd0, cause_out}, 64'd0);
        check({tag, " pc"}, pc_out, 64'h180);
        set_idle;
    endtask

    initial begin
        set_idle;
        rst = 1;
        tick; tick;
        #1;
        check("rst mem_req", {63'd0, mem_req}, 64'd0);
        check("rst stall", {63'd0, stall_out}, 64'd0);
        check("rst pc_out", pc_out, 64'd0);
        check("rst result_out", result_out, 64'd0);
        check("rst cause_out", {59'd0, cause_out}, 64'd0);
        tick;
        rst = 0;

        // Non-memory pass-through and upstream exception pass-through.
        in_rd = 5'd3; in_result = 64'h1234; in_pc = 64'h200; #1;
        check("alu mem_req", {63'd0, mem_req}, 64'd0);
        check("alu stall", {63'd0, stall_out}, 64'd0);
        tick;
        check("alu rd", {59'd0, rd_out}, 64'd3);
        check("alu result", result_out, 64'h1234);
        check("alu pc", pc_out, 64'h200);
        set_op(1'b1, 1'b0, 2'd3, 1'b0, 64'h8000, 64'd0, 5'd4, 64'h210);
        in_cause = 5'd2; in_tval = 64'hDEAD; #1;
        check("upexc mem_req", {63'd0, mem_req}, 64'd0);
        tick;
        check("upexc cause", {59'd0, cause_out}, 64'd2);
        check("upexc tval", tval_out, 64'hDEAD);
        check("upexc rd", {59'd0, rd_out}, 64'd4);
        set_idle;

        // Loads of every size and extension mode.
        do_load("ld",  2'd3, 1'b0, 64'h1000, 64'h8877665544332211, 64'h8877665544332211);
        do_load("lb",  2'd0, 1'b0, 64'h1003, 64'h0000000080000000, 64'hFFFFFFFFFFFFFF80);
        do_load("lbu", 2'd0, 1'b1, 64'h1003, 64'h0000000080000000, 64'h0000000000000080);
        do_load("lw",  2'd2, 1'b0, 64'h1004, 64'h8000000100000000, 64'hFFFFFFFF80000001);
        do_load("lhu", 2'd1, 1'b1, 64'h1002, 64'h00000000F00D0000, 64'h000000000000F00D);

        do_store("sh", 2'd1, 64'h1006, 64'h0000_0000_0000_ABCD, 8'hC0, 64'hABCDABCDABCDABCD);
        do_store("sb", 2'd0, 64'h1005, 64'h0000_0000_0000_005A, 8'h20, 64'h5A5A5A5A5A5A5A5A);

        // Misaligned load and store.
        set_op(1'b1, 1'b0, 2'd2, 1'b0, 64'h1002, 64'd0, 5'd7, 64'h500); #1;
        check("lw mis mem_req", {63'd0, mem_req}, 64'd0);
        check("lw mis stall", {63'd0, stall_out}, 64'd0);
        tick;
        check("lw mis cause", {59'd0, cause_out}, 64'd4);
        check("lw mis tval", tval_out, 64'h1002);
        check("lw mis rd", {59'd0, rd_out}, 64'd0);
        set_op(1'b0, 1'b1, 2'd3, 1'b0, 64'h1004, 64'd1, 5'd0, 64'h504); #1;
        check("sd mis mem_req", {63'd0, mem_req}, 64'd0);
        tick;
        check("sd mis cause", {59'd0, cause_out}, 64'd6);
        set_idle;

        // Delayed acceptance followed by an error response.
        set_op(1'b1, 1'b0, 2'd2, 1'b0, 64'h2004, 64'd0, 5'd6, 64'h300);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold req", {63'd0, mem_req}, 64'd1);
            check("hold addr", mem_addr, 64'h2000);
            check("hold strb", {56'd0, mem_wstrb}, 64'hF0);
            check("hold stall", {63'd0, stall_out}, 64'd1);
            tick;
            check("hold bubble rd", {59'd0, rd_out}, 64'd0);
        end
        mem_ready = 1; #1;
        check("hold req accept", {63'd0, mem_req}, 64'd1);
        tick;
        mem_ready = 0; mem_rvalid = 1; mem_err = 1;
        tick;
        check("err cause", {59'd0, cause_out}, 64'd5);
        check("err tval", tval_out, 64'h2004);
        check("err rd", {59'd0, rd_out}, 64'd0);
        set_idle;

        // Store with no response: timeout fault, then drain the late response.
        set_op(1'b0, 1'b1, 2'd3, 1'b0, 64'h3000, 64'h55, 5'd0, 64'h400);
        mem_ready = 1;
        tick;
        mem_ready = 0;
        repeat (TIMEOUT - 2) tick;
        #1;
        check("tmo stall before", {63'd0, stall_out}, 64'd1);
        tick; #1;
        check("tmo stall hit", {63'd0, stall_out}, 64'd0);
        tick;
        check("tmo cause", {59'd0, cause_out}, 64'd7);
        check("tmo tval", tval_out, 64'h3000);
        set_idle;
        set_op(1'b1, 1'b0, 2'd3, 1'b0, 64'h4000, 64'd0, 5'd8, 64'h410); #1;
        check("drain stall", {63'd0, stall_out}, 64'd1);
        check("drain no req", {63'd0, mem_req}, 64'd0);
        mem_rvalid = 1; mem_rdata = 64'h1111;
        tick;
        check("drain bubble rd", {59'd0, rd_out}, 64'd0);
        check("drain bubble result", result_out, 64'd0);
        do_load("after tmo", 2'd3, 1'b0, 64'h4000, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF);

        // Clear while waiting; the late response must be discarded.
        set_op(1'b1, 1'b0, 2'd3, 1'b0, 64'h5000, 64'd0, 5'd9, 64'h600);
        mem_ready = 1;
        tick;
        mem_ready = 0; clear = 1; #1;
        check("clr wait stall", {63'd0, stall_out}, 64'd0);
        tick;
        check("clr wait bubble rd", {59'd0, rd_out}, 64'd0);
        check("clr wait bubble cause", {59'd0, cause_out}, 64'd0);
        clear = 0;
        set_op(1'b1, 1'b0, 2'd3, 1'b0, 64'h5008, 64'd0, 5'd10, 64'h604); #1;
        check("clr drain no req", {63'd0, mem_req}, 64'd0);
        mem_rvalid = 1; mem_rdata = 64'hDEADBEEF;
        tick;
        check("clr discard rd", {59'd0, rd_out}, 64'd0);
        check("clr discard result", result_out, 64'd0);
        mem_rvalid = 0; mem_ready = 1; #1;
        check("clr next req", {63'd0, mem_req}, 64'd1);
        check("clr next addr", mem_addr, 64'h5008);
        tick;
        mem_ready = 0; mem_rvalid = 1; mem_rdata = 64'h1122334455667788;
        tick;
        check("clr next result", result_out, 64'h1122334455667788);
        check("clr next rd", {59'd0, rd_out}, 64'd10);
        set_idle;

        // Clear while the request is still unaccepted.
        set_op(1'b0, 1'b1, 2'd2, 1'b0, 64'h6000, 64'h77, 5'd0, 64'h700); #1;
        check("clr req issue", {63'd0, mem_req}, 64'd1);
        tick;
        clear = 1; #1;
        check("clr req drop", {63'd0, mem_req}, 64'd0);
        check("clr req stall", {63'd0, stall_out}, 64'd0);
        tick;
        check("clr req bubble pc", pc_out, 64'd0);
        set_idle; #1;
        check("clr req idle", {63'd0, mem_req}, 64'd0);
        tick;

        // Reset in the middle of a transaction.
        set_op(1'b1, 1'b0, 2'd3, 1'b0, 64'h7000, 64'd0, 5'd11, 64'h800);
        mem_ready = 1;
        tick;
        set_idle;
        rst = 1;
        tick; #1;
        check("midrst stall", {63'd0, stall_out}, 64'd0);
        check("midrst rd", {59'd0, rd_out}, 64'd0);
        tick;
        rst = 0;
        do_load("after rst", 2'd1, 1'b0, 64'h7006, 64'h8001000000000000, 64'hFFFFFFFFFFFF8001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
